// File: rtl/ntt_transpose_out_if.sv
// Handshake bundle for the NTT write-back transpose stage.
// master: producer of data_i / consumer of data_o (upstream+downstream side)
// slave:  the transpose stage itself
interface ntt_transpose_out_if #(
  parameter int unsigned REG_SIZE = 23
);
  localparam int unsigned WORD_W = 4 * REG_SIZE;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] data_i;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] data_o;
  logic              out_last;

  modport master (
    output in_valid, data_i, out_ready,
    input  in_ready, out_valid, data_o, out_last
  );

  modport slave (
    input  in_valid, data_i, out_ready,
    output in_ready, out_valid, data_o, out_last
  );
endinterface

// File: rtl/ntt_transpose_out.sv
// Streaming 4x4 coefficient transpose with ping-pong banks (NTT write-back side).
// Four input words fill one bank; the bank is then read out column-wise so that
// lane k of every output word comes from input word k.
// Optional feature macro: NTT_XPOSE_PASSTHRU_EN adds a passthru port and a
// per-bank mode bit that forwards rows unchanged instead of transposing.
module ntt_transpose_out #(
  parameter int unsigned REG_SIZE = 23
) (
  input  logic clk,
  input  logic reset,
  input  logic zeroize,
  input  logic flush,
`ifdef NTT_XPOSE_PASSTHRU_EN
  input  logic passthru,
`endif
  ntt_transpose_out_if.slave bus
);

  localparam int unsigned ROWS   = 4;
  localparam int unsigned LANES  = 4;
  localparam int unsigned BANKS  = 2;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned WORD_W = LANES * REG_SIZE;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROWS - 1);

  logic [REG_SIZE-1:0] bank_q [BANKS][ROWS][LANES];
  logic                wr_bank_q;
  logic                rd_bank_q;
  logic [CNT_W-1:0]    wr_cnt_q;
  logic [CNT_W-1:0]    rd_cnt_q;
  logic [BANKS-1:0]    full_q;
  logic [BANKS-1:0]    full_nxt;
`ifdef NTT_XPOSE_PASSTHRU_EN
  logic [BANKS-1:0]    mode_q;
`endif

  logic              in_acc;
  logic              out_acc;
  logic [WORD_W-1:0] data_c;

  // Flow control is derived only from registered occupancy flags
  assign bus.in_ready  = !full_q[wr_bank_q];
  assign bus.out_valid = full_q[rd_bank_q];
  assign bus.out_last  = full_q[rd_bank_q] && (rd_cnt_q == CNT_LAST);
  assign bus.data_o    = data_c;

  assign in_acc  = bus.in_valid && !full_q[wr_bank_q];
  assign out_acc = full_q[rd_bank_q] && bus.out_ready;

  // Column select of the read bank: lane k <- row k, lane rd_cnt
  always_comb begin
    data_c = '0;
    for (int k = 0; k < int'(LANES); k++) begin
`ifdef NTT_XPOSE_PASSTHRU_EN
      if (mode_q[rd_bank_q]) begin
        data_c[k*REG_SIZE +: REG_SIZE] = bank_q[rd_bank_q][rd_cnt_q][k];
      end else begin
        data_c[k*REG_SIZE +: REG_SIZE] = bank_q[rd_bank_q][k][rd_cnt_q];
      end
`else
      data_c[k*REG_SIZE +: REG_SIZE] = bank_q[rd_bank_q][k][rd_cnt_q];
`endif
    end
  end

  // Occupancy update; a completing write and a completing read always hit
  // different banks, so set and clear never collide
  always_comb begin
    full_nxt = full_q;
    if (in_acc && (wr_cnt_q == CNT_LAST)) begin
      full_nxt[wr_bank_q] = 1'b1;
    end
    if (out_acc && (rd_cnt_q == CNT_LAST)) begin
      full_nxt[rd_bank_q] = 1'b0;
    end
  end

  // Pointer, flag and bank storage update (reset > zeroize > flush > handshakes)
  always_ff @(posedge clk) begin
    if (reset || zeroize) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      full_q    <= '0;
`ifdef NTT_XPOSE_PASSTHRU_EN
      mode_q    <= '0;
`endif
      for (int b = 0; b < int'(BANKS); b++) begin
        for (int r = 0; r < int'(ROWS); r++) begin
          for (int l = 0; l < int'(LANES); l++) begin
            bank_q[b][r][l] <= '0;
          end
        end
      end
    end else if (flush) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      full_q    <= '0;
    end else begin
      if (in_acc) begin
        for (int l = 0; l < int'(LANES); l++) begin
          bank_q[wr_bank_q][wr_cnt_q][l] <= bus.data_i[l*REG_SIZE +: REG_SIZE];
        end
`ifdef NTT_XPOSE_PASSTHRU_EN
        if (wr_cnt_q == '0) begin
          mode_q[wr_bank_q] <= passthru;
        end
`endif
        wr_cnt_q <= CNT_W'(wr_cnt_q + CNT_W'(1));
        if (wr_cnt_q == CNT_LAST) begin
          wr_bank_q <= !wr_bank_q;
        end
      end
      if (out_acc) begin
        rd_cnt_q <= CNT_W'(rd_cnt_q + CNT_W'(1));
        if (rd_cnt_q == CNT_LAST) begin
          rd_bank_q <= !rd_bank_q;
        end
      end
      full_q <= full_nxt;
    end
  end

endmodule

// File: tb/tb_ntt_transpose_out.sv
// Self-checking bench for ntt_transpose_out: table-driven single-block checks,
// a block-level reference model feeding an expected-output queue, and
// hand-written sequences for backpressure, flush and zeroize.
module tb_ntt_transpose_out;

  localparam int unsigned RS = 23;
  localparam int unsigned WW = 4 * RS;

  typedef logic [WW-1:0] word_t;
  typedef struct {
    word_t data;
    logic  last;
  } exp_t;
  typedef struct {
    word_t din;
    word_t dout;
    word_t dpass;
    logic  last;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic zeroize = 1'b0;
  logic flush = 1'b0;
`ifdef NTT_XPOSE_PASSTHRU_EN
  logic passthru = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  word_t mblk [4];
  int    mcnt = 0;
  logic  mmode = 1'b0;
  exp_t  exp_q [$];
  logic  in_acc = 1'b0;
  vec_t  vec [4];

  always #5 clk = ~clk;

  ntt_transpose_out_if #(.REG_SIZE(RS)) bus ();

  ntt_transpose_out #(.REG_SIZE(RS)) dut (
    .clk     (clk),
    .reset   (reset),
    .zeroize (zeroize),
    .flush   (flush),
`ifdef NTT_XPOSE_PASSTHRU_EN
    .passthru(passthru),
`endif
    .bus     (bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_w(input string nm, input word_t act, input word_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  // Expected output word j of the captured block
  function automatic word_t model_word(input int j, input logic pt);
    word_t r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (pt) r[k*RS +: RS] = mblk[j][k*RS +: RS];
      else    r[k*RS +: RS] = mblk[k][j*RS +: RS];
    end
    return r;
  endfunction

  // One clock: sample at negedge (scoreboard + model), return #1 after posedge
  task automatic tick();
    exp_t e;
    @(negedge clk);
    in_acc = bus.in_valid && bus.in_ready;
    if (!reset && !zeroize && !flush) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got data_o=%h with empty expectation queue", bus.data_o);
        end else begin
          e = exp_q.pop_front();
          chk_w("sb_data", bus.data_o, e.data);
          chk_b("sb_last", bus.out_last, e.last);
        end
      end
      if (in_acc) begin
`ifdef NTT_XPOSE_PASSTHRU_EN
        if (mcnt == 0) mmode = passthru;
`else
        if (mcnt == 0) mmode = 1'b0;
`endif
        mblk[mcnt] = bus.data_i;
        mcnt++;
        if (mcnt == 4) begin
          for (int j = 0; j < 4; j++) begin
            e.data = model_word(j, mmode);
            e.last = (j == 3);
            exp_q.push_back(e);
          end
          mcnt = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    mcnt = 0;
    exp_q.delete();
  endtask

  // Present a word and wait (bounded) until accepted; in_valid left asserted
  task automatic send(input word_t w);
    int n;
    bus.in_valid = 1'b1;
    bus.data_i   = w;
    n = 0;
    do begin
      tick();
      n++;
    end while (!in_acc && n < 64);
    if (!in_acc) begin
      n_checks++;
      $display("FAIL send_timeout: word %h not accepted after %0d cycles", w, n);
    end
  endtask

  task automatic drain();
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 64) begin
      tick();
      n++;
    end
    chk_b("drain_empty", exp_q.size() == 0, 1'b1);
  endtask

  function automatic word_t rnd_word();
    return WW'({$urandom, $urandom, $urandom});
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk_b({tag, "_in_ready"}, bus.in_ready, 1'b1);
    chk_b({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk_b({tag, "_out_last"}, bus.out_last, 1'b0);
    chk_w({tag, "_data_o"}, bus.data_o, '0);
  endtask

  initial begin
    word_t held_d;
    logic  held_l;

    bus.in_valid  = 1'b0;
    bus.data_i    = '0;
    bus.out_ready = 1'b0;

    // Reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
    check_reset_outputs("reset");

    // Table: w_k lane j = 16k+j; output j lane k = 16k+j
    for (int k = 0; k < 4; k++) begin
      vec[k].din = '0;
      vec[k].dout = '0;
      vec[k].last = (k == 3);
    end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        vec[k].din[j*RS +: RS]  = RS'(16 * k + j);
        vec[j].dout[k*RS +: RS] = RS'(16 * k + j);
      end
    end
    for (int k = 0; k < 4; k++) vec[k].dpass = vec[k].din;

    // Single block transpose
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.data_i   = vec[i].din;
      chk_b("fill_in_ready", bus.in_ready, 1'b1);
      chk_b("fill_out_valid", bus.out_valid, 1'b0);
      tick();
      chk_b("fill_acc", in_acc, 1'b1);
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_b("tbl_out_valid", bus.out_valid, 1'b1);
      chk_w("tbl_data_o", bus.data_o, vec[i].dout);
      chk_b("tbl_out_last", bus.out_last, vec[i].last);
      tick();
    end
    chk_b("tbl_idle_out_valid", bus.out_valid, 1'b0);
    chk_b("tbl_sb_empty", exp_q.size() == 0, 1'b1);

    // Streaming 12 words; covers last-read B0 coinciding with last-write B1
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_valid = 1'b1;
      bus.data_i   = rnd_word();
      chk_b("stream_in_ready", bus.in_ready, 1'b1);
      if (i >= 4) chk_b("stream_out_valid", bus.out_valid, 1'b1);
      tick();
      chk_b("stream_acc", in_acc, 1'b1);
    end
    bus.in_valid = 1'b0;
    chk_b("stream_tail_valid", bus.out_valid, 1'b1);
    drain();

    // Backpressure: both banks full, 9th word held
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(rnd_word());
    bus.in_valid = 1'b1;
    bus.data_i   = rnd_word();
    chk_b("bp_in_ready", bus.in_ready, 1'b0);
    chk_b("bp_out_valid", bus.out_valid, 1'b1);
    held_d = bus.data_o;
    held_l = bus.out_last;
    tick();
    chk_b("bp_not_acc", in_acc, 1'b0);
    tick();
    chk_w("bp_hold_data", bus.data_o, held_d);
    chk_b("bp_hold_last", bus.out_last, held_l);
    chk_b("bp_hold_valid", bus.out_valid, 1'b1);
    bus.out_ready = 1'b1;
    send(bus.data_i);
    for (int i = 0; i < 3; i++) send(rnd_word());
    drain();

    // Flush after two words, with a handshake offered in the flush cycle
    bus.out_ready = 1'b1;
    send(rnd_word());
    send(rnd_word());
    bus.in_valid = 1'b1;
    bus.data_i   = rnd_word();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    chk_b("flush_out_valid", bus.out_valid, 1'b0);
    chk_b("flush_in_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < 4; i++) send(rnd_word());
    drain();

    // Zeroize with both banks full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(rnd_word());
    chk_b("zf_in_ready", bus.in_ready, 1'b0);
    chk_b("zf_out_valid", bus.out_valid, 1'b1);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    check_reset_outputs("zeroize");

`ifdef NTT_XPOSE_PASSTHRU_EN
    // Passthru block: output j equals input word j
    bus.out_ready = 1'b1;
    passthru = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vec[i].din);
      passthru = 1'b0;
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_b("pt_out_valid", bus.out_valid, 1'b1);
      chk_w("pt_data_o", bus.data_o, vec[i].dpass);
      tick();
    end
    chk_b("pt_sb_empty", exp_q.size() == 0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
